// File: rtl/host_read_port_if.sv
// Host read port signal bundle: host bus side, VRAM arbiter side and transceiver control.
// The slave modport is the read port itself; master is whatever drives the host/arbiter side.
interface host_read_port_if;
  logic [10:0] host_bus_addr;
  logic        n_host_rmem;
  logic        n_host_vram_en;
  logic [1:0]  bank_sel;
  logic        host_rd_req;
  logic [12:0] host_rd_addr;
  logic        host_rd_grant;
  logic [7:0]  host_rd_data;
  logic [7:0]  host_out_data;
  logic        host_out_en;
  logic        host_bus_dir;
  logic        rd_timeout;

  modport master (
    output host_bus_addr, n_host_rmem, n_host_vram_en, bank_sel, host_rd_grant, host_rd_data,
    input  host_rd_req, host_rd_addr, host_out_data, host_out_en, host_bus_dir, rd_timeout
  );

  modport slave (
    input  host_bus_addr, n_host_rmem, n_host_vram_en, bank_sel, host_rd_grant, host_rd_data,
    output host_rd_req, host_rd_addr, host_out_data, host_out_en, host_bus_dir, rd_timeout
  );
endinterface

// File: rtl/host_read_port.sv
// Services host VRAM reads: latches the address, requests an arbiter slot, captures the byte
// and drives it through the transceiver until the host strobe is released.
module host_read_port #(
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic             clk,
  input logic             nrst,
  host_read_port_if.slave bus
);

  localparam int unsigned LatW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StReq, StWaitData, StDrive} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rmem_sync_q, en_sync_q;
  logic        rd_qual;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
  logic        req_q, req_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        out_en_q, out_en_d;
  logic        dir_q, dir_d;
  logic        timeout_q, timeout_d;

  assign rd_qual = ~rmem_sync_q[1] & ~en_sync_q[1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rmem_sync_q <= 2'b11;
      en_sync_q   <= 2'b11;
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      out_en_q    <= 1'b0;
      dir_q       <= 1'b1;
      timeout_q   <= 1'b0;
    end else begin
      rmem_sync_q <= {rmem_sync_q[0], bus.n_host_rmem};
      en_sync_q   <= {en_sync_q[0], bus.n_host_vram_en};
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      out_en_q    <= out_en_d;
      dir_q       <= dir_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    lat_cnt_d = lat_cnt_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    out_en_d  = out_en_q;
    dir_d     = dir_q;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (rd_qual) begin
          addr_d    = {bus.bank_sel, bus.host_bus_addr};
          req_d     = 1'b1;
          timeout_d = 1'b0;
          tmo_cnt_d = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        // A strobe release wins over a grant in the same cycle.
        if (!rd_qual) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (bus.host_rd_grant) begin
          req_d     = 1'b0;
          dir_d     = 1'b0;
          lat_cnt_d = LatW'(RD_LATENCY - 1);
          state_d   = StWaitData;
        end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          req_d     = 1'b0;
          data_d    = 8'hFF;
          timeout_d = 1'b1;
          dir_d     = 1'b0;
          state_d   = StDrive;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StWaitData: begin
        if (!rd_qual) begin
          dir_d   = 1'b1;
          state_d = StIdle;
        end else if (lat_cnt_q == '0) begin
          data_d   = bus.host_rd_data;
          out_en_d = 1'b1;
          state_d  = StDrive;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      StDrive: begin
        // Timeout entry turns the direction first; output enable follows one cycle later.
        if (!rd_qual) begin
          out_en_d = 1'b0;
          dir_d    = 1'b1;
          state_d  = StIdle;
        end else begin
          out_en_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.host_rd_req   = req_q;
  assign bus.host_rd_addr  = addr_q;
  assign bus.host_out_data = data_q;
  assign bus.host_out_en   = out_en_q;
  assign bus.host_bus_dir  = dir_q;
  assign bus.rd_timeout    = timeout_q;

endmodule

// File: tb/tb_host_read_port.sv
// Bench for host_read_port: table of complete reads plus timeout, abort and reset sequences;
// expected bytes are queued at request time and popped when the port starts driving.
module tb_host_read_port;

  localparam int unsigned RD_LATENCY     = 2;
  localparam int unsigned TIMEOUT_CYCLES = 64;

  typedef struct {
    logic [1:0]  bank;
    logic [10:0] addr;
    int          gnt_dly;
    logic [7:0]  rdata;
    bit          rel_en;
    logic [12:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  logic clk;
  logic nrst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb[$];
  vec_t vecs[5];

  host_read_port_if bus ();

  host_read_port #(
    .RD_LATENCY    (RD_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nrst) begin
      checks++;
      if (bus.host_out_en && bus.host_bus_dir) begin
        errors++;
        $display("FAIL order: hostOutEn=1 with hostBusDir=1 at %0t, required hostBusDir=0", $time);
      end
      if (bus.host_rd_req && (bus.host_out_en || !bus.host_bus_dir)) begin
        errors++;
        $display("FAIL req_overlap: hostRdReq=1 with en=%0b dir=%0b, required en=0 dir=1",
                 bus.host_out_en, bus.host_bus_dir);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got output %0h with empty scoreboard, required none", name,
               bus.host_out_data);
    end else begin
      exp = sb.pop_front();
      check(name, bus.host_out_data, exp);
    end
  endtask

  task automatic wait_req(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.host_rd_req) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.host_out_en && bus.host_bus_dir) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
    check({name, "_req"}, bus.host_rd_req, 0);
  endtask

  task automatic strobes_high();
    @(posedge clk);
    #1;
    bus.n_host_rmem    = 1'b1;
    bus.n_host_vram_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input bit do_release);
    bit ok;
    bus.bank_sel       = v.bank;
    bus.host_bus_addr  = v.addr;
    bus.host_rd_data   = ~v.rdata;
    bus.n_host_rmem    = 1'b0;
    bus.n_host_vram_en = 1'b0;
    wait_req("req_rise", ok);
    if (!ok) begin
      strobes_high();
      return;
    end
    check("rd_addr", bus.host_rd_addr, v.exp_addr);
    check("rd_timeout_clr", bus.rd_timeout, 0);
    sb.push_back(v.exp_data);
    // Host address moves after the strobe; the latched address must not follow.
    bus.bank_sel      = ~v.bank;
    bus.host_bus_addr = ~v.addr;
    if (v.gnt_dly > 1) begin
      repeat (v.gnt_dly - 1) @(posedge clk);
      #1;
    end
    bus.host_rd_grant = 1'b1;
    @(posedge clk);
    #1;
    bus.host_rd_grant = 1'b0;
    @(negedge clk);
    check("dir_after_grant", bus.host_bus_dir, 0);
    check("req_after_grant", bus.host_rd_req, 0);
    check("en_wait", bus.host_out_en, 0);
    if (RD_LATENCY > 1) begin
      repeat (RD_LATENCY - 1) @(posedge clk);
      #1;
    end
    bus.host_rd_data = v.rdata;
    @(posedge clk);
    #1;
    bus.host_rd_data = ~v.rdata;
    @(negedge clk);
    check("en_drive", bus.host_out_en, 1);
    pop_check("out_data");
    check("dir_drive", bus.host_bus_dir, 0);
    check("addr_held", bus.host_rd_addr, v.exp_addr);
    @(negedge clk);
    check("data_stable", bus.host_out_data, v.exp_data);
    if (!do_release) return;
    @(posedge clk);
    #1;
    if (v.rel_en) bus.n_host_vram_en = 1'b1;
    else          bus.n_host_rmem    = 1'b1;
    wait_idle("release_idle");
    strobes_high();
  endtask

  initial begin
    bit ok;
    int n;
    bit bad;

    vecs[0] = '{2'd1, 11'h123, 3, 8'hA5, 1'b0, 13'h0923, 8'hA5};
    vecs[1] = '{2'd2, 11'h000, 1, 8'h5A, 1'b1, 13'h1000, 8'h5A};
    vecs[2] = '{2'd3, 11'h7FF, 2, 8'h3C, 1'b0, 13'h1FFF, 8'h3C};
    vecs[3] = '{2'd0, 11'h2AB, 6, 8'hC3, 1'b1, 13'h02AB, 8'hC3};
    vecs[4] = '{2'd2, 11'h555, 1, 8'h00, 1'b0, 13'h1555, 8'h00};

    nrst               = 1'b0;
    bus.host_bus_addr  = '0;
    bus.bank_sel       = '0;
    bus.n_host_rmem    = 1'b1;
    bus.n_host_vram_en = 1'b1;
    bus.host_rd_grant  = 1'b0;
    bus.host_rd_data   = '0;
    #7;
    check("rst_req", bus.host_rd_req, 0);
    check("rst_addr", bus.host_rd_addr, 0);
    check("rst_data", bus.host_out_data, 0);
    check("rst_en", bus.host_out_en, 0);
    check("rst_dir", bus.host_bus_dir, 1);
    check("rst_timeout", bus.rd_timeout, 0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], 1'b1);

    // Arbiter never grants.
    bus.bank_sel       = 2'd1;
    bus.host_bus_addr  = 11'h0AA;
    bus.n_host_rmem    = 1'b0;
    bus.n_host_vram_en = 1'b0;
    wait_req("tmo_req", ok);
    if (ok) begin
      sb.push_back(8'hFF);
      n = 1;
      for (int i = 0; i < int'(TIMEOUT_CYCLES) + 8; i++) begin
        @(negedge clk);
        if (!bus.host_rd_req) break;
        n++;
      end
      check("tmo_len", n, TIMEOUT_CYCLES);
      check("tmo_flag", bus.rd_timeout, 1);
      check("tmo_dir", bus.host_bus_dir, 0);
      check("tmo_en_late", bus.host_out_en, 0);
      pop_check("tmo_data");
      @(negedge clk);
      check("tmo_en", bus.host_out_en, 1);
    end
    @(posedge clk);
    #1;
    bus.n_host_rmem = 1'b1;
    wait_idle("tmo_idle");
    check("tmo_sticky", bus.rd_timeout, 1);
    strobes_high();
    run_txn(vecs[0], 1'b1);

    // Abort in REQ, with a grant landing in the very cycle the release is seen.
    bus.bank_sel       = 2'd0;
    bus.host_bus_addr  = 11'h010;
    bus.n_host_rmem    = 1'b0;
    bus.n_host_vram_en = 1'b0;
    wait_req("abreq_req", ok);
    bus.n_host_rmem = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.host_rd_grant = 1'b1;
    @(negedge clk);
    check("abreq_req_held", bus.host_rd_req, ok);
    @(posedge clk);
    #1;
    bus.host_rd_grant = 1'b0;
    @(negedge clk);
    check("abreq_req_drop", bus.host_rd_req, 0);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.host_out_en || !bus.host_bus_dir) bad = 1'b1;
      @(negedge clk);
    end
    check("abreq_quiet", bad, 0);
    strobes_high();

    // Abort in WAIT_DATA: release reaches the synchroniser output one cycle after the grant.
    bus.bank_sel       = 2'd2;
    bus.host_bus_addr  = 11'h020;
    bus.n_host_rmem    = 1'b0;
    bus.n_host_vram_en = 1'b0;
    wait_req("abwait_req", ok);
    bus.n_host_rmem = 1'b1;
    @(posedge clk);
    #1;
    bus.host_rd_grant = 1'b1;
    @(posedge clk);
    #1;
    bus.host_rd_grant = 1'b0;
    bus.host_rd_data  = 8'h77;
    @(negedge clk);
    check("abwait_granted", bus.host_bus_dir, 0);
    @(negedge clk);
    check("abwait_dir", bus.host_bus_dir, 1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.host_out_en) bad = 1'b1;
      @(negedge clk);
    end
    check("abwait_no_en", bad, 0);
    strobes_high();
    run_txn(vecs[2], 1'b1);

    // Reset mid-DRIVE with the strobe held; a fresh read follows release.
    run_txn(vecs[1], 1'b0);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_en", bus.host_out_en, 0);
    check("arst_dir", bus.host_bus_dir, 1);
    check("arst_req", bus.host_rd_req, 0);
    check("arst_data", bus.host_out_data, 0);
    check("arst_addr", bus.host_rd_addr, 0);
    @(negedge clk);
    nrst = 1'b1;
    run_txn(vecs[3], 1'b1);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
